fabric_arbiter: RTL and testbench

FABRIC_ARBITER -- requirements
Module: fabric_arbiter

---
 rtl/fabric_arbiter.sv | 169 ++++++++++++++++
 tb/tb_fabric_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fabric_arbiter.sv
// Round-robin arbiter sharing one fabric port among NUM_REQ requesters; one transaction in flight.
// req->gnt 1 cycle, done 1 cycle after fab_resp_valid (or after TIMEOUT wait cycles); req is held until gnt.
module fabric_arbiter #(
  parameter int WIDTH   = 32,
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ-1:0]       req_write,
  input  logic [NUM_REQ*WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [NUM_REQ-1:0]       done,
  output logic                     err,
  output logic [WIDTH-1:0]         rdata,
  output logic                     busy,
  output logic                     fab_read_req,
  output logic                     fab_write_req,
  output logic [WIDTH-1:0]         fab_write_data,
  input  logic [WIDTH-1:0]         fab_read_data,
  input  logic                     fab_resp_valid
);

  localparam int         IDX_W    = $clog2(NUM_REQ);
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT
  } state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]     owner_q, owner_d;
  logic                 write_q, write_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic                 err_q, err_d;
  logic                 busy_q, busy_d;
  logic                 fab_read_req_q, fab_read_req_d;
  logic                 fab_write_req_q, fab_write_req_d;
  logic [WIDTH-1:0]     rdata_q, rdata_d;
  logic [WIDTH-1:0]     fab_write_data_q, fab_write_data_d;

  logic                 win_vld;
  logic [IDX_W-1:0]     win_idx;
  logic [IDX_W-1:0]     cand;
  logic [WIDTH-1:0]     win_wdata;

  // First requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin : rr_search
    win_vld = 1'b0;
    win_idx = rr_ptr_q;
    cand    = rr_ptr_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IDX_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (!win_vld && req[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  always_comb begin : wdata_mux
    win_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_idx == IDX_W'(i)) begin
        win_wdata = req_wdata[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin : next_state
    state_d          = state_q;
    rr_ptr_d         = rr_ptr_q;
    owner_d          = owner_q;
    write_d          = write_q;
    cnt_d            = cnt_q;
    gnt_d            = '0;
    done_d           = '0;
    err_d            = 1'b0;
    rdata_d          = rdata_q;
    fab_read_req_d   = 1'b0;
    fab_write_req_d  = 1'b0;
    fab_write_data_d = fab_write_data_q;

    case (state_q)
      ST_IDLE: begin
        // Outputs are registered, so the ISSUE-cycle strobes are loaded on this edge.
        if (win_vld) begin
          state_d          = ST_ISSUE;
          owner_d          = win_idx;
          write_d          = req_write[win_idx];
          rr_ptr_d         = IDX_W'((int'(win_idx) + 1) % NUM_REQ);
          gnt_d            = NUM_REQ'(1) << win_idx;
          fab_write_req_d  = req_write[win_idx];
          fab_read_req_d   = !req_write[win_idx];
          fab_write_data_d = win_wdata;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
        cnt_d   = '0;
      end
      ST_WAIT: begin
        cnt_d = cnt_q + 8'd1;
        if (fab_resp_valid) begin
          state_d = ST_IDLE;
          done_d  = NUM_REQ'(1) << owner_q;
          if (!write_q) begin
            rdata_d = fab_read_data;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
          done_d  = NUM_REQ'(1) << owner_q;
          err_d   = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= ST_IDLE;
      rr_ptr_q         <= '0;
      owner_q          <= '0;
      write_q          <= 1'b0;
      cnt_q            <= '0;
      gnt_q            <= '0;
      done_q           <= '0;
      err_q            <= 1'b0;
      busy_q           <= 1'b0;
      fab_read_req_q   <= 1'b0;
      fab_write_req_q  <= 1'b0;
      rdata_q          <= '0;
      fab_write_data_q <= '0;
    end else begin
      state_q          <= state_d;
      rr_ptr_q         <= rr_ptr_d;
      owner_q          <= owner_d;
      write_q          <= write_d;
      cnt_q            <= cnt_d;
      gnt_q            <= gnt_d;
      done_q           <= done_d;
      err_q            <= err_d;
      busy_q           <= busy_d;
      fab_read_req_q   <= fab_read_req_d;
      fab_write_req_q  <= fab_write_req_d;
      rdata_q          <= rdata_d;
      fab_write_data_q <= fab_write_data_d;
    end
  end

  assign gnt            = gnt_q;
  assign done           = done_q;
  assign err            = err_q;
  assign rdata          = rdata_q;
  assign busy           = busy_q;
  assign fab_read_req   = fab_read_req_q;
  assign fab_write_req  = fab_write_req_q;
  assign fab_write_data = fab_write_data_q;

endmodule

// File: tb/tb_fabric_arbiter.sv
// Bench for fabric_arbiter: transaction-level timing model plus a one-word fabric memory.
// Directed scenarios run first, then randomized traffic.
module tb_fabric_arbiter;

  localparam int W  = 32;
  localparam int N  = 4;
  localparam int TO = 8;
  localparam int IW = $clog2(N);

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req, req_write;
  logic [N*W-1:0] req_wdata;
  logic [N-1:0]   gnt, done;
  logic           err, busy, fab_read_req, fab_write_req, fab_resp_valid;
  logic [W-1:0]   rdata, fab_write_data, fab_read_data;

  fabric_arbiter #(.WIDTH(W), .NUM_REQ(N), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_write(req_write), .req_wdata(req_wdata),
    .gnt(gnt), .done(done), .err(err), .rdata(rdata), .busy(busy),
    .fab_read_req(fab_read_req), .fab_write_req(fab_write_req),
    .fab_write_data(fab_write_data), .fab_read_data(fab_read_data),
    .fab_resp_valid(fab_resp_valid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Model: one transaction at a time, described by its strobe and done cycles.
  int           cyc = 0;
  int           m_ptr, m_s, m_done, resp_at, m_owner = 0;
  logic         m_write = 1'b0, m_err = 1'b0;
  logic [W-1:0] m_mem = '0, resp_dat = '0;
  logic [W-1:0] cur_wdata, cur_rdata, pend_wdata = '0, pend_rdata = '0;
  int           pend_wdata_cyc, pend_rdata_cyc;

  // Requester and fabric stimulus state.
  logic [N-1:0] pend_req = '0, pend_wr = '0, force_pulse = '0;
  logic [W-1:0] pend_dat [N];
  int           newreq_pct = 0, pulse_pct = 0, wr_pct = 50, resp_mode = 1;

  int           gnt_cyc[$], done_cyc[$];
  logic [N-1:0] gnt_val[$], done_val[$];
  logic         done_err[$];

  function automatic logic [N-1:0] onehot(input int i);
    onehot = '0;
    for (int k = 0; k < N; k++) if (k == i) onehot[k] = 1'b1;
  endfunction

  task automatic clear_logs();
    gnt_cyc.delete(); gnt_val.delete();
    done_cyc.delete(); done_val.delete(); done_err.delete();
  endtask

  task automatic model_reset();
    m_ptr = 0; m_s = -1; m_done = -1; resp_at = -1; m_err = 1'b0;
    cur_wdata = '0; cur_rdata = '0;
    pend_wdata_cyc = -1; pend_rdata_cyc = -1;
    pend_req = '0;
  endtask

  task automatic arbitrate(input logic [N-1:0] r, input logic [N-1:0] wr, input logic [N*W-1:0] dat);
    int w = -1;
    int d;
    logic [IW-1:0] idx;
    logic [W-1:0] wd = '0;
    for (int k = 0; k < N; k++) begin
      idx = IW'((m_ptr + k) % N);
      if (w < 0 && r[idx]) w = int'(idx);
    end
    for (int i = 0; i < N; i++) begin
      if (i == w) begin
        m_write = wr[i];
        wd = dat[i*W +: W];
        pend_req[i] = 1'b0;
      end
    end
    m_ptr = (w + 1) % N;
    m_owner = w;
    m_s = cyc + 1;
    pend_wdata = wd;
    pend_wdata_cyc = m_s;
    case (resp_mode)
      1: d = 1;
      2: d = TO + 1;
      default: d = (int'($urandom_range(0, 2)) != 0) ? 1 : int'($urandom_range(1, TO + 1));
    endcase
    if (d <= TO) begin
      resp_at = m_s + d; m_err = 1'b0; m_done = m_s + d + 1;
    end else begin
      resp_at = -1; m_err = 1'b1; m_done = m_s + TO + 1;
    end
    if (m_write) begin
      m_mem = wd;
      resp_dat = $urandom;
    end else begin
      resp_dat = m_mem;
      if (!m_err) begin
        pend_rdata = m_mem;
        pend_rdata_cyc = m_done;
      end
    end
  endtask

  // One cycle: check outputs at the negedge, then drive inputs for the coming posedge.
  task automatic step();
    logic [N-1:0]   drv_req, drv_wr, oh, exp_g, exp_d;
    logic [N*W-1:0] drv_dat;
    logic           idle_now;
    @(negedge clk);
    cyc++;
    if (cyc == pend_wdata_cyc) cur_wdata = pend_wdata;
    if (cyc == pend_rdata_cyc) cur_rdata = pend_rdata;
    oh    = onehot(m_owner);
    exp_g = (cyc == m_s) ? oh : '0;
    exp_d = (cyc == m_done) ? oh : '0;
    chk("gnt", 64'(gnt), 64'(exp_g));
    chk("done", 64'(done), 64'(exp_d));
    chk("err", 64'(err), 64'((cyc == m_done) && m_err));
    chk("busy", 64'(busy), 64'((cyc >= m_s) && (cyc < m_done)));
    chk("fab_rd", 64'(fab_read_req), 64'((cyc == m_s) && !m_write));
    chk("fab_wr", 64'(fab_write_req), 64'((cyc == m_s) && m_write));
    chk("fab_wdata", 64'(fab_write_data), 64'(cur_wdata));
    chk("rdata", 64'(rdata), 64'(cur_rdata));
    if (gnt != '0) begin gnt_cyc.push_back(cyc); gnt_val.push_back(gnt); end
    if (done != '0) begin done_cyc.push_back(cyc); done_val.push_back(done); done_err.push_back(err); end

    for (int i = 0; i < N; i++) begin
      if (!pend_req[i] && int'($urandom_range(0, 99)) < newreq_pct) begin
        pend_req[i] = 1'b1;
        pend_wr[i]  = (int'($urandom_range(0, 99)) < wr_pct);
        pend_dat[i] = $urandom;
      end
      drv_req[i] = pend_req[i];
      drv_wr[i]  = pend_req[i] ? pend_wr[i] : 1'($urandom_range(0, 1));
      drv_dat[i*W +: W] = pend_req[i] ? pend_dat[i] : $urandom;
      if (!pend_req[i] && int'($urandom_range(0, 99)) < pulse_pct) drv_req[i] = 1'b1;
    end
    drv_req = drv_req | force_pulse;
    force_pulse = '0;
    if (!rst_n) drv_req = '0;
    req = drv_req; req_write = drv_wr; req_wdata = drv_dat;

    idle_now = (cyc >= m_done);
    fab_resp_valid = (cyc == resp_at) || ((idle_now || cyc == m_s) && $urandom_range(0, 3) == 0);
    fab_read_data  = (cyc == resp_at) ? resp_dat : $urandom;
    if (rst_n && idle_now && drv_req != '0) arbitrate(drv_req, drv_wr, drv_dat);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_gnt"}, 64'(gnt), 64'(0));
    chk({tag, "_done"}, 64'(done), 64'(0));
    chk({tag, "_err"}, 64'(err), 64'(0));
    chk({tag, "_rdata"}, 64'(rdata), 64'(0));
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_frd"}, 64'(fab_read_req), 64'(0));
    chk({tag, "_fwr"}, 64'(fab_write_req), 64'(0));
    chk({tag, "_fwdata"}, 64'(fab_write_data), 64'(0));
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    check_zero(tag);
    model_reset();
    repeat (2) step();
    rst_n = 1'b1;
  endtask

  task automatic wait_gnt(input int n, input int budget);
    int b = 0;
    while (gnt_cyc.size() < n && b < budget) begin step(); b++; end
    chk("gnt_wait", 64'(gnt_cyc.size()), 64'(n));
  endtask

  task automatic wait_done(input int n, input int budget);
    int b = 0;
    while (done_cyc.size() < n && b < budget) begin step(); b++; end
    chk("done_wait", 64'(done_cyc.size()), 64'(n));
  endtask

  task automatic drain();
    int b = 0;
    pend_req = '0; newreq_pct = 0; pulse_pct = 0;
    while (cyc <= m_done && b < 40) begin step(); b++; end
    chk("drain", 64'(cyc > m_done), 64'(1));
  endtask

  function automatic int gc(input int k);
    gc = (k < gnt_cyc.size()) ? gnt_cyc[k] : -100;
  endfunction

  function automatic logic [N-1:0] gv(input int k);
    gv = (k < gnt_val.size()) ? gnt_val[k] : '0;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int n2;
    logic [W-1:0] rd_before;
    logic [N-1:0] exp_order [5];
    rst_n = 1'b1; req = '0; req_write = '0; req_wdata = '0;
    fab_read_data = '0; fab_resp_valid = 1'b0;
    for (int i = 0; i < N; i++) pend_dat[i] = '0;
    model_reset();
    #2;
    do_reset("rst0");

    // Write 0xDEADBEEF via requester 1, then read it back.
    wr_pct = 0; resp_mode = 1; clear_logs();
    pend_req[1] = 1'b1; pend_wr[1] = 1'b1; pend_dat[1] = 32'hDEADBEEF;
    t0 = cyc + 1;
    wait_done(1, 20);
    chk("wr_gnt_lat", 64'(gc(0) - t0), 64'(1));
    chk("wr_done_lat", 64'(done_cyc.size() > 0 ? done_cyc[0] - t0 : -1), 64'(3));
    clear_logs();
    pend_req[1] = 1'b1; pend_wr[1] = 1'b0; pend_dat[1] = $urandom;
    t0 = cyc + 1;
    wait_done(1, 20);
    chk("rd_gnt_lat", 64'(gc(0) - t0), 64'(1));
    chk("rd_done_lat", 64'(done_cyc.size() > 0 ? done_cyc[0] - t0 : -1), 64'(3));
    chk("rd_data", 64'(rdata), 64'(32'hDEADBEEF));
    chk("rd_err", 64'(done_err.size() > 0 ? done_err[0] : 1'b1), 64'(0));
    drain();

    // Full contention, reads only.
    do_reset("rst1");
    clear_logs(); resp_mode = 1; wr_pct = 0; newreq_pct = 100;
    pend_req = '1; pend_wr = '0;
    wait_gnt(5, 40);
    exp_order[0] = 4'b0001; exp_order[1] = 4'b0010; exp_order[2] = 4'b0100;
    exp_order[3] = 4'b1000; exp_order[4] = 4'b0001;
    for (int k = 0; k < 5; k++) chk($sformatf("cont_ord%0d", k), 64'(gv(k)), 64'(exp_order[k]));
    for (int k = 1; k < 5; k++) chk($sformatf("cont_gap%0d", k), 64'(gc(k) - gc(k - 1)), 64'(3));
    drain();

    // Wrap: grant 3, then req 1001 -> 0 then 3.
    do_reset("rst2");
    clear_logs(); resp_mode = 1;
    pend_req[3] = 1'b1; pend_wr[3] = 1'b0;
    wait_gnt(1, 10);
    pend_req[0] = 1'b1; pend_wr[0] = 1'b0;
    pend_req[3] = 1'b1;
    wait_gnt(3, 20);
    chk("wrap0", 64'(gv(0)), 64'(4'b1000));
    chk("wrap1", 64'(gv(1)), 64'(4'b0001));
    chk("wrap2", 64'(gv(2)), 64'(4'b1000));
    drain();

    // Timeout with no fabric response.
    clear_logs(); resp_mode = 2; rd_before = cur_rdata;
    pend_req[2] = 1'b1; pend_wr[2] = 1'b0;
    wait_done(1, 30);
    chk("to_done", 64'(done_val.size() > 0 ? done_val[0] : '0), 64'(4'b0100));
    chk("to_err", 64'(done_err.size() > 0 ? done_err[0] : 1'b0), 64'(1));
    chk("to_gap", 64'(done_cyc.size() > 0 ? done_cyc[0] - gc(0) : -1), 64'(TO + 1));
    chk("to_rdata", 64'(rdata), 64'(rd_before));
    drain();

    // Reset in the middle of WAIT.
    clear_logs(); resp_mode = 2;
    pend_req[1] = 1'b1; pend_wr[1] = 1'b1; pend_dat[1] = $urandom;
    wait_gnt(1, 10);
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    check_zero("rstw");
    model_reset();
    clear_logs();
    repeat (3) step();
    chk("rstw_nodone", 64'(done_cyc.size()), 64'(0));
    rst_n = 1'b1;
    resp_mode = 1;
    pend_req[2] = 1'b1; pend_wr[2] = 1'b0;
    wait_gnt(1, 10);
    chk("rstw_gnt2", 64'(gv(0)), 64'(4'b0100));
    drain();

    // One-cycle req[2] pulse while busy is never served.
    clear_logs(); resp_mode = 2;
    pend_req[0] = 1'b1; pend_wr[0] = 1'b0;
    wait_gnt(1, 10);
    repeat (2) step();
    force_pulse = 4'b0100;
    step();
    drain();
    repeat (4) step();
    n2 = 0;
    foreach (gnt_val[k]) if (gnt_val[k][2]) n2++;
    chk("drop_gnt2", 64'(n2), 64'(0));
    chk("drop_ngnt", 64'(gnt_cyc.size()), 64'(1));

    // Randomized traffic.
    resp_mode = 0; wr_pct = 50; newreq_pct = 30; pulse_pct = 5;
    repeat (3000) step();
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
